// File: rtl/fir_mac_engine.sv
// fir_mac_engine: tick-driven single-multiplier FIR with saturating output and runtime coefficients
module fir_mac_engine #(
  parameter int NTAPS = 16,
  parameter int DW = 12,
  parameter int CW = 12,
  parameter int AW = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic signed [DW-1:0] x_in,
  input  logic                 coef_we,
  input  logic [AW-1:0]        coef_addr,
  input  logic signed [CW-1:0] coef_data,
  output logic signed [DW-1:0] y_out,
  output logic                 y_valid,
  output logic                 busy,
  output logic                 overrun
);
  localparam int IW = $clog2(NTAPS);
  localparam int ACCW = DW + CW + IW;
  localparam logic [IW-1:0] LAST = IW'(NTAPS - 1);
  localparam logic [AW:0] NT = (AW + 1)'(NTAPS);
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  state_t st, nst;
  logic s1, s2, s3, tick_rise, coef_ok, ovp, ovn;
  logic [IW-1:0] idx;
  logic signed [DW-1:0] dl [NTAPS];
  logic signed [CW-1:0] coef [NTAPS];
  logic signed [DW+CW-1:0] prod;
  logic signed [ACCW-1:0] acc, acc_nx, shr;
  logic signed [DW-1:0] sat;
  assign tick_rise = s2 & ~s3;
  assign coef_ok = coef_we && st == IDLE && {1'b0, coef_addr} < NT;
  assign prod = coef[idx] * dl[idx];
  assign acc_nx = acc + $signed({{(ACCW-DW-CW){prod[DW+CW-1]}}, prod});
  assign shr = acc_nx >>> (CW - 1);
  assign ovp = !shr[ACCW-1] && (|shr[ACCW-2:DW-1]);
  assign ovn = shr[ACCW-1] && !(&shr[ACCW-2:DW-1]);
  assign sat = ovp ? {1'b0, {(DW-1){1'b1}}} : ovn ? {1'b1, {(DW-1){1'b0}}} : shr[DW-1:0];
  assign busy = st != IDLE;
  assign y_valid = st == OUT;
  always_comb begin
    nst = (st == IDLE && tick_rise) ? MAC :
          (st == MAC && idx == LAST) ? OUT :
          (st == OUT) ? IDLE : st;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {s3, s2, s1} <= '0;
      st <= IDLE;
      idx <= '0;
      acc <= '0;
      y_out <= '0;
      overrun <= 1'b0;
      for (int k = 0; k < NTAPS; k++) begin
        dl[k] <= '0;
        coef[k] <= '0;
      end
    end else begin
      {s3, s2, s1} <= {s2, s1, sample_tick};
      st <= nst;
      if (tick_rise && st != IDLE) overrun <= 1'b1;
      if (coef_ok) coef[coef_addr[IW-1:0]] <= coef_data;
      if (st == IDLE && tick_rise) begin
        dl[0] <= x_in;
        for (int k = 1; k < NTAPS; k++) dl[k] <= dl[k-1];
        acc <= '0;
        idx <= '0;
      end
      if (st == MAC) begin
        acc <= acc_nx;
        idx <= idx + 1'b1;
        if (idx == LAST) y_out <= sat;
      end
    end
  end
endmodule

// File: doc/fir_mac_engine.md
# fir_mac_engine

Sequential non-recursive (FIR) filter core for the audio path. Sits directly downstream of the sample-rate divider: each rising edge of the divider's `sample_tick` output captures one input sample, shifts it into an internal delay line and runs a single-multiplier multiply-accumulate over all taps on the 100 MHz system clock. Emits one saturated filtered sample per tick with a one-cycle valid strobe. Coefficients are runtime-loadable through a simple write port.

## Interface
- `NTAPS`, 16: number of filter taps (2..64).
- `DW`, 12: signed sample width, input and output.
- `CW`, 12: signed coefficient width, Q1.(CW-1) format.
- `AW`, 6: coefficient address width, so that 2^AW ≥ NTAPS.
- `clk` in 1: system clock, 100 MHz. All logic on the rising edge.
- `reset` in 1: asynchronous, active-low; asserted when 0.
- `sample_tick` in 1: sample clock from the divider. Treated as asynchronous and synchronised internally. Only rising edges are used.
- `x_in` in DW: signed input sample. Upstream holds it stable for at least 4 clk cycles after each `sample_tick` rising edge.
- `coef_we` in 1: coefficient write enable, one-cycle pulse.
- `coef_addr` in AW: tap index of the write. Tap 0 multiplies the newest sample.
- `coef_data` in CW: signed coefficient value.
- `y_out` out DW: signed filtered sample, held until the next result.
- `y_valid` out 1: one-cycle pulse when `y_out` updates.
- `busy` out 1: high while the MAC is in progress.
- `overrun` out 1: sticky error flag. Cleared only by reset.

## Operation
- **Tick detection.** `sample_tick` passes through a 2-flop synchroniser plus an edge register. `tick_rise` = sync2 & ~sync3.
- **Delay line.** NTAPS×DW registers. On an accepted tick, `x_in` enters tap 0 and every other sample moves down one tap; the oldest sample is discarded.
- **FSM states.**
  - IDLE: on `tick_rise`, shift the delay line, clear the accumulator, set tap index = 0, go to MAC.
  - MAC: acc += coef[i] × x[i]; i increments each cycle. After i = NTAPS-1, go to OUT.
  - OUT: load `y_out`, pulse `y_valid`, return to IDLE.
- **Arithmetic.**
  - Products are DW+CW bits.
  - The accumulator is ACCW = DW+CW+ceil(log2 NTAPS) bits, so it cannot overflow.
  - Result = acc >>> (CW-1), arithmetic shift (floor, no rounding).
  - The result saturates to [-2^(DW-1), 2^(DW-1)-1].
- **Overrun.** A `tick_rise` in MAC or OUT is dropped: no shift, no restart. It sets `overrun`=1.
- **Coefficient writes.**
  - Accepted only in IDLE, with `coef_addr` < NTAPS.
  - Writes in MAC/OUT, or to an out-of-range address, are silently dropped.
  - If a write and `tick_rise` coincide in IDLE, both take effect. The MAC uses the new coefficient.
- **Reset values.** Delay line 0, coefficients 0, accumulator 0, FSM in IDLE. Outputs: `y_out`=0, `y_valid`=0, `busy`=0, `overrun`=0. Synchroniser flops = 0, so a tick input already high at reset release produces one `tick_rise`.
- **Reset mid-operation.** Reset asserted in any state immediately aborts the MAC. No `y_valid` is produced for the aborted sample, and the delay line clears.

## Timing
- Let cycle T be the first clk edge at which the synchronised `tick_rise` = 1. This is 2–3 cycles after the raw `sample_tick` edge.
- Cycle T: `x_in` is sampled and shifted in; the FSM goes to MAC.
- `busy`=1 from T+1 through T+NTAPS+1, inclusive.
- MAC occupies cycles T+1..T+NTAPS.
- OUT at T+NTAPS+1: `y_out` is updated and `y_valid`=1 during that cycle.
- Latency from `tick_rise` to `y_valid` = NTAPS+1 cycles (17 at default).
- Minimum tick spacing without overrun = NTAPS+2 clk cycles. At 44.1 kHz with a 100 MHz clock, the margin is over 2000 cycles.
- `y_valid` never asserts on two consecutive cycles.

## Test plan
- **Impulse response.**
  - Stimulus: coef[k] = 100·(k+1); one tick with x_in = 2047, then ticks with x_in = 0.
  - Required: successive `y_out` = floor(2047·100·(k+1)/2048) for k = 0..15, then 0.
- **Positive saturation.** All coef = 2047, x_in = 2047 on every tick. The 2nd and later outputs = 2047; no wraparound.
- **Negative saturation.** All coef = 2047, x_in = -2048. Output clamps at -2048.
- **Overrun.**
  - Stimulus: second `tick_rise` 5 cycles after the first.
  - Required: `overrun` = 1 and stays 1; one `y_valid` only; delay line shifted once.
- **Reset mid-MAC.**
  - Stimulus: assert reset at T+8.
  - Required: all outputs 0 immediately; no `y_valid`. The next tick after release with coef = 0 yields `y_out` = 0.
- **Write while busy.** Write coef[0] = 500 at T+3; ignored, and the result matches the old coefficient. The same write in IDLE takes effect on the next sample.
